regfile_access_arbiter: RTL and testbench

- Shares the single general-purpose register file port between NUM_REQ requesters, for example the control unit, the debug/load port and the interrupt context saver.
- Round-robin arbitration; sequences each access as a one-cycle issue to the register file, then a one-cycle response.
- The register file samples its controls on the falling clock edge. The arbiter runs on the rising edge and drives stable controls for one full cycle per access.

---
 rtl/regfile_access_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing the single register-file port between NUM_REQ requesters.
// Each access is one ISSUE cycle (controls stable for the RF's falling-edge sample) then one RESP cycle.
module regfile_access_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 4,
    parameter int ID_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [SEL_W-1:0]          rf_select,
    output logic [DATA_W-1:0]         rf_data_in,
    output logic                      rf_read,
    output logic                      rf_write,
    output logic                      rf_enable,
    input  logic [DATA_W-1:0]         rf_data_out
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     grant_id_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;
    logic [SEL_W-1:0]    rf_select_q;
    logic [DATA_W-1:0]   rf_data_in_q;
    logic                rf_read_q;
    logic                rf_write_q;
    logic                rf_enable_q;

    logic [NUM_REQ-1:0]  cand;
    logic                win_found_d;
    logic [ID_W-1:0]     win_idx_d;
    logic                win_we_d;
    logic [SEL_W-1:0]    win_sel_d;
    logic [DATA_W-1:0]   win_wdata_d;

    // ack_q is one-hot on the winner during RESP and zero elsewhere, so it also
    // masks the requester whose req is still high while it is being acknowledged.
    assign cand = req & ~ack_q;

    // Two passes: indices above last_grant first, then wrap to 0..last_grant.
    always_comb begin
        // NOTE: every variable gets a default before the search so no path can infer a latch.
        win_found_d = 1'b0;
        win_idx_d   = '0;
        win_we_d    = 1'b0;
        win_sel_d   = '0;
        win_wdata_d = '0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!win_found_d && cand[c] && (c > int'(last_grant_q))) begin
                win_found_d = 1'b1;
                win_idx_d   = ID_W'(c);
                win_we_d    = req_we[c];
                win_sel_d   = req_sel[c*SEL_W +: SEL_W];
                win_wdata_d = req_wdata[c*DATA_W +: DATA_W];
            end
        end
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!win_found_d && cand[c] && (c <= int'(last_grant_q))) begin
                win_found_d = 1'b1;
                win_idx_d   = ID_W'(c);
                win_we_d    = req_we[c];
                win_sel_d   = req_sel[c*SEL_W +: SEL_W];
                win_wdata_d = req_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments, so every
    // read inside this block sees the value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            rf_select_q  <= '0;
            rf_data_in_q <= '0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            rf_enable_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, RESP: begin
                    ack_q <= '0;
                    if (win_found_d) begin
                        state_q      <= ISSUE;
                        busy_q       <= 1'b1;
                        grant_id_q   <= win_idx_d;
                        last_grant_q <= win_idx_d;
                        rf_enable_q  <= 1'b1;
                        rf_write_q   <= win_we_d;
                        rf_read_q    <= ~win_we_d;
                        rf_select_q  <= win_sel_d;
                        rf_data_in_q <= win_we_d ? win_wdata_d : '0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state_q <= RESP;
                    // The RF drove rf_data_out at the mid-cycle falling edge.
                    if (rf_read_q) begin
                        rdata_q <= rf_data_out;
                    end
                    ack_q        <= NUM_REQ'(1) << grant_id_q;
                    rf_enable_q  <= 1'b0;
                    rf_read_q    <= 1'b0;
                    rf_write_q   <= 1'b0;
                    rf_select_q  <= '0;
                    rf_data_in_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign rf_select  = rf_select_q;
    assign rf_data_in = rf_data_in_q;
    assign rf_read    = rf_read_q;
    assign rf_write   = rf_write_q;
    assign rf_enable  = rf_enable_q;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a falling-edge register-file model.
// Expected values are hand-derived from the access timing (grant edge -> ISSUE -> RESP/ack).
module tb_regfile_access_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int SEL_W   = 4;
    localparam int ID_W    = 3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*SEL_W-1:0]  req_sel;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic [SEL_W-1:0]          rf_select;
    logic [DATA_W-1:0]         rf_data_in;
    logic                      rf_read;
    logic                      rf_write;
    logic                      rf_enable;
    logic [DATA_W-1:0]         rf_data_out;

    logic [DATA_W-1:0]         mem [1<<SEL_W];

    int checks = 0;
    int errors = 0;

    regfile_access_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .ID_W   (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_sel    (req_sel),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .rf_select  (rf_select),
        .rf_data_in (rf_data_in),
        .rf_read    (rf_read),
        .rf_write   (rf_write),
        .rf_enable  (rf_enable),
        .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file: acts on the falling edge in the middle of the ISSUE cycle.
    initial begin
        for (int i = 0; i < (1 << SEL_W); i++) mem[i] = '0;
        rf_data_out = '0;
    end

    always @(negedge clk) begin
        if (rf_enable === 1'b1) begin
            if (rf_write === 1'b1) mem[rf_select] <= rf_data_in;
            if (rf_read === 1'b1)  rf_data_out <= mem[rf_select];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: strobe invariants checked mid-cycle, then outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        check("rd_wr_exclusive", {31'd0, rf_read & rf_write}, 32'd0);
        check("strobe_needs_en", {31'd0, (rf_read | rf_write) & ~rf_enable}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [SEL_W-1:0] sel,
                           input logic [DATA_W-1:0] wd);
        req_we[i]                   = we;
        req_sel[i*SEL_W +: SEL_W]   = sel;
        req_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_we    = '0;
        req_sel   = '0;
        req_wdata = '0;
        tick();
        tick();

        check("rst_ack",      ack,        0);
        check("rst_busy",     busy,       0);
        check("rst_grant_id", grant_id,   0);
        check("rst_rdata",    rdata,      0);
        check("rst_rf_en",    rf_enable,  0);
        check("rst_rf_rd",    rf_read,    0);
        check("rst_rf_wr",    rf_write,   0);
        check("rst_rf_sel",   rf_select,  0);
        check("rst_rf_din",   rf_data_in, 0);
        reset = 1'b0;

        // Single write then read by requester 0
        set_req(0, 1'b1, 4'd3, 8'hA5);
        req = 2'b01;
        tick();
        check("t1w_issue_busy", busy,       1);
        check("t1w_issue_en",   rf_enable,  1);
        check("t1w_issue_wr",   rf_write,   1);
        check("t1w_issue_rd",   rf_read,    0);
        check("t1w_issue_sel",  rf_select,  3);
        check("t1w_issue_din",  rf_data_in, 8'hA5);
        check("t1w_issue_gid",  grant_id,   0);
        check("t1w_issue_ack",  ack,        0);
        tick();
        check("t1w_resp_ack",   ack,        2'b01);
        check("t1w_resp_wr",    rf_write,   0);
        check("t1w_resp_en",    rf_enable,  0);
        check("t1w_resp_busy",  busy,       1);
        req = 2'b00;
        tick();
        check("t1w_idle_ack",   ack,        0);
        check("t1w_idle_busy",  busy,       0);
        check("t1w_idle_gid",   grant_id,   0);

        set_req(0, 1'b0, 4'd3, 8'h00);
        req = 2'b01;
        tick();
        check("t1r_issue_rd",   rf_read,    1);
        check("t1r_issue_wr",   rf_write,   0);
        check("t1r_issue_din",  rf_data_in, 0);
        check("t1r_issue_sel",  rf_select,  3);
        tick();
        check("t1r_resp_ack",   ack,        2'b01);
        check("t1r_resp_rdata", rdata,      8'hA5);
        req = 2'b00;
        tick();
        check("t1r_idle_ack",   ack,        0);
        check("t1r_idle_rdata", rdata,      8'hA5);

        // Simultaneous requests out of reset: 0 writes sel1, 1 reads sel1
        reset = 1'b1;
        set_req(0, 1'b1, 4'd1, 8'h11);
        set_req(1, 1'b0, 4'd1, 8'h00);
        req = 2'b11;
        tick();
        reset = 1'b0;
        tick();
        check("t2_issue0_gid",  grant_id,   0);
        check("t2_issue0_wr",   rf_write,   1);
        check("t2_issue0_sel",  rf_select,  1);
        check("t2_issue0_din",  rf_data_in, 8'h11);
        tick();
        check("t2_resp0_ack",   ack,        2'b01);
        req = 2'b10;
        tick();
        check("t2_issue1_gid",  grant_id,   1);
        check("t2_issue1_ack",  ack,        0);
        check("t2_issue1_busy", busy,       1);
        check("t2_issue1_rd",   rf_read,    1);
        tick();
        check("t2_resp1_ack",   ack,        2'b10);
        check("t2_resp1_rdata", rdata,      8'h11);
        req = 2'b00;
        tick();
        check("t2_idle_busy",   busy,       0);

        // Round-robin: both reading continuously (req0 sel3 = A5, req1 sel1 = 11)
        set_req(0, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b0, 4'd1, 8'h00);
        req = 2'b11;
        for (int a = 0; a < 8; a++) begin
            tick();
            check("rr_issue_gid", grant_id, (a % 2));
            check("rr_issue_rd",  rf_read,  1);
            tick();
            check("rr_resp_ack",   ack,   ((a % 2) == 0) ? 32'h1 : 32'h2);
            check("rr_resp_rdata", rdata, ((a % 2) == 0) ? 32'hA5 : 32'h11);
        end
        req = 2'b00;
        tick();
        check("rr_idle_busy", busy, 0);

        // Lone requester holding req: ISSUE, RESP, forced IDLE, ISSUE again
        req = 2'b01;
        tick();
        check("solo_issue_gid", grant_id, 0);
        tick();
        check("solo_resp_ack",  ack,      2'b01);
        tick();
        check("solo_gap_busy",  busy,     0);
        check("solo_gap_ack",   ack,      0);
        tick();
        check("solo_issue2_busy", busy,   1);
        check("solo_issue2_rd",   rf_read, 1);
        req = 2'b00;
        tick();
        check("solo_dropped_ack", ack,    2'b01);
        tick();

        // Reset during ISSUE of a read by requester 1
        set_req(1, 1'b0, 4'd1, 8'h00);
        req = 2'b10;
        tick();
        check("t4_issue_gid", grant_id, 1);
        check("t4_issue_rd",  rf_read,  1);
        reset = 1'b1;
        tick();
        check("t4_rst_ack",   ack,       0);
        check("t4_rst_busy",  busy,      0);
        check("t4_rst_rd",    rf_read,   0);
        check("t4_rst_en",    rf_enable, 0);
        check("t4_rst_gid",   grant_id,  0);
        check("t4_rst_rdata", rdata,     0);
        check("t4_rst_sel",   rf_select, 0);
        reset = 1'b0;
        set_req(0, 1'b0, 4'd3, 8'h00);
        req = 2'b11;
        tick();
        check("t4_after_gid", grant_id, 0);
        check("t4_after_ack", ack,      0);
        tick();
        check("t4_after_resp_ack",   ack,   2'b01);
        check("t4_after_resp_rdata", rdata, 8'hA5);
        req = 2'b00;
        tick();
        check("t4_idle_ack",  ack,  0);
        check("t4_idle_busy", busy, 0);

        // Write data changes during ISSUE must be ignored
        set_req(0, 1'b1, 4'd5, 8'h5A);
        req = 2'b01;
        tick();
        set_req(0, 1'b1, 4'd5, 8'hFF);
        check("t5_issue_din", rf_data_in, 8'h5A);
        tick();
        check("t5_resp_ack",        ack,   2'b01);
        check("t5_rdata_held_wr",   rdata, 8'hA5);
        req = 2'b00;
        tick();
        set_req(0, 1'b0, 4'd5, 8'h00);
        req = 2'b01;
        tick();
        check("t5_rb_issue_sel", rf_select, 5);
        tick();
        check("t5_rb_ack",   ack,   2'b01);
        check("t5_rb_rdata", rdata, 8'h5A);
        req = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
